response_tree_pe: RTL and testbench



---
 rtl/peripheral_interco_pkg.sv | 31 +++
 rtl/outstanding_cnt_pe.sv | 36 +++
 rtl/response_tree_pe.sv | 109 ++++++++++
 tb/tb_response_tree_pe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_interco_pkg.sv
// Shared definitions for the peripheral interconnect: one-hot ID helpers and
// the response payload type carried through the response pipeline register.
package peripheral_interco_pkg;

  // Helpers take IDs zero-extended to this width so any tree size up to 64
  // masters can share one function body.
  localparam int MAX_ID_WIDTH    = 64;
  localparam int IDX_WIDTH       = $clog2(MAX_ID_WIDTH);
  localparam int RESP_DATA_WIDTH = 32;

  typedef struct packed {
    logic [RESP_DATA_WIDTH-1:0] rdata;
    logic                       opc;
  } resp_t;

  // True when exactly one bit is set.
  function automatic logic is_onehot(input logic [MAX_ID_WIDTH-1:0] vec);
    return (vec != '0) && ((vec & (vec - MAX_ID_WIDTH'(1))) == '0);
  endfunction

  // Index of the set bit; only meaningful when is_onehot(vec) holds.
  function automatic logic [IDX_WIDTH-1:0] onehot_to_bin(input logic [MAX_ID_WIDTH-1:0] vec);
    logic [IDX_WIDTH-1:0] bin;
    bin = '0;
    for (int i = 0; i < MAX_ID_WIDTH; i++) begin
      if (vec[i]) bin = bin | IDX_WIDTH'(i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/outstanding_cnt_pe.sv
// Saturating up/down counter of in-flight transactions for one master.
// Simultaneous inc and dec cancel out.
module outstanding_cnt_pe #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc_i,
  input  logic                 dec_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

  logic [CNT_WIDTH-1:0] cnt_q;

  // Count register; the bounds guard makes the counter saturate at both ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
      // NOTE: state is updated with <= so every register samples pre-edge values.
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_WIDTH'(1);
    end
  end

  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == CNT_MAX);
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/response_tree_pe.sv
// Response side of the peripheral arbitration tree: routes slave responses to
// the issuing master by one-hot ID through one pipeline register, tracks the
// outstanding transactions per master and flags illegal issues/responses.
module response_tree_pe
  import peripheral_interco_pkg::*;
#(
  parameter int N_MASTER        = 16,
  parameter int DATA_WIDTH      = RESP_DATA_WIDTH,
  parameter int ID_WIDTH        = N_MASTER,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req_i,
  input  logic                  data_gnt_i,
  input  logic [ID_WIDTH-1:0]   data_ID_i,
  input  logic                  data_r_valid_i,
  input  logic [DATA_WIDTH-1:0] data_r_rdata_i,
  input  logic                  data_r_opc_i,
  input  logic [ID_WIDTH-1:0]   data_r_ID_i,
  output logic [N_MASTER-1:0]   data_r_valid_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata_o [N_MASTER],
  output logic [N_MASTER-1:0]   data_r_opc_o,
  output logic [N_MASTER-1:0]   outstanding_full_o,
  output logic                  resp_err_o,
  output logic                  issue_err_o
);

  localparam int                   IDX_W   = $clog2(N_MASTER);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

  logic [IDX_W-1:0]     issue_idx, resp_idx;
  logic                 issue, issue_legal, resp_legal;
  logic [N_MASTER-1:0]  inc, dec, full, empty;
  logic [CNT_WIDTH-1:0] cnt [N_MASTER];

  logic [N_MASTER-1:0]  r_valid_q;
  resp_t                resp_q;
  logic                 resp_err_q, issue_err_q;

  // ID decode and legality checks, all against the registered counts.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    issue_idx   = IDX_W'(onehot_to_bin(MAX_ID_WIDTH'(data_ID_i)));
    resp_idx    = IDX_W'(onehot_to_bin(MAX_ID_WIDTH'(data_r_ID_i)));
    issue       = data_req_i && data_gnt_i;
    issue_legal = issue && is_onehot(MAX_ID_WIDTH'(data_ID_i)) && (cnt[issue_idx] < CNT_MAX);
    resp_legal  = data_r_valid_i && is_onehot(MAX_ID_WIDTH'(data_r_ID_i)) && !empty[resp_idx];
    inc         = issue_legal ? N_MASTER'(data_ID_i)   : '0;
    dec         = resp_legal  ? N_MASTER'(data_r_ID_i) : '0;
  end

  for (genvar g = 0; g < N_MASTER; g++) begin : g_cnt
    outstanding_cnt_pe #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (inc[g]),
      .dec_i   (dec[g]),
      .cnt_o   (cnt[g]),
      .full_o  (full[g]),
      .empty_o (empty[g])
    );
  end

  // Response pipeline register; payload only loads on a legal response so it
  // holds its last value otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload is a handful of flops, not a memory, so it is reset
      // to give masters a clean zero after reset.
      r_valid_q <= '0;
      resp_q    <= '0;
    end else begin
      r_valid_q <= resp_legal ? N_MASTER'(data_r_ID_i) : '0;
      if (resp_legal) begin
        resp_q <= '{rdata: RESP_DATA_WIDTH'(data_r_rdata_i), opc: data_r_opc_i};
      end
    end
  end

  // Registered one-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_err_q  <= 1'b0;
      issue_err_q <= 1'b0;
    end else begin
      resp_err_q  <= data_r_valid_i && !resp_legal;
      issue_err_q <= issue && !issue_legal;
    end
  end

  // Fan the shared payload register out to every master.
  always_comb begin
    for (int i = 0; i < N_MASTER; i++) begin
      data_r_rdata_o[i] = DATA_WIDTH'(resp_q.rdata);
    end
  end

  assign data_r_valid_o     = r_valid_q;
  assign data_r_opc_o       = {N_MASTER{resp_q.opc}};
  assign outstanding_full_o = full;
  assign resp_err_o         = resp_err_q;
  assign issue_err_o        = issue_err_q;

endmodule

// File: tb/tb_response_tree_pe.sv
// Self-checking bench for response_tree_pe (4 masters, 2 outstanding):
// directed vector table, reset-mid-operation sequence, then random traffic
// against a behavioural model.
module tb_response_tree_pe;

  localparam int NM = 4;
  localparam int DW = 32;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          data_req_i, data_gnt_i, data_r_valid_i, data_r_opc_i;
  logic [NM-1:0] data_ID_i, data_r_ID_i;
  logic [DW-1:0] data_r_rdata_i;
  logic [NM-1:0] data_r_valid_o, data_r_opc_o, outstanding_full_o;
  logic [DW-1:0] data_r_rdata_o [NM];
  logic          resp_err_o, issue_err_o;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int            m_cnt [NM];
  logic [DW-1:0] m_rdata;
  logic          m_opc;
  logic [NM-1:0] e_valid;
  logic          e_rerr, e_ierr;

  always #5 clk = ~clk;

  response_tree_pe #(
    .N_MASTER        (NM),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .data_req_i         (data_req_i),
    .data_gnt_i         (data_gnt_i),
    .data_ID_i          (data_ID_i),
    .data_r_valid_i     (data_r_valid_i),
    .data_r_rdata_i     (data_r_rdata_i),
    .data_r_opc_i       (data_r_opc_i),
    .data_r_ID_i        (data_r_ID_i),
    .data_r_valid_o     (data_r_valid_o),
    .data_r_rdata_o     (data_r_rdata_o),
    .data_r_opc_o       (data_r_opc_o),
    .outstanding_full_o (outstanding_full_o),
    .resp_err_o         (resp_err_o),
    .issue_err_o        (issue_err_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bit_pos(input logic [NM-1:0] v);
    for (int i = 0; i < NM; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [NM-1:0] model_full();
    logic [NM-1:0] f;
    for (int i = 0; i < NM; i++) f[i] = (m_cnt[i] == MO);
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NM; i++) m_cnt[i] = 0;
    m_rdata = '0;
    m_opc   = 1'b0;
  endtask

  // Predict the post-edge outputs from the current inputs and in-flight counts.
  task automatic model_step();
    int ri, ii;
    bit rl, il;
    ri = bit_pos(data_r_ID_i);
    ii = bit_pos(data_ID_i);
    rl = 0;
    il = 0;
    if (data_r_valid_i && $countones(data_r_ID_i) == 1)
      rl = (m_cnt[ri] > 0);
    if (data_req_i && data_gnt_i && $countones(data_ID_i) == 1)
      il = (m_cnt[ii] < MO);
    e_valid = rl ? data_r_ID_i : '0;
    e_rerr  = data_r_valid_i && !rl;
    e_ierr  = data_req_i && data_gnt_i && !il;
    if (rl) begin
      m_rdata = data_r_rdata_i;
      m_opc   = data_r_opc_i;
      m_cnt[ri] = m_cnt[ri] - 1;
    end
    if (il) m_cnt[ii] = m_cnt[ii] + 1;
  endtask

  // Apply one cycle of inputs, update the model, land 1 ns after the edge.
  task automatic drive(input logic req, input logic gnt, input logic [NM-1:0] id,
                       input logic rv, input logic [NM-1:0] rid,
                       input logic [DW-1:0] rd, input logic op);
    data_req_i     = req;
    data_gnt_i     = gnt;
    data_ID_i      = id;
    data_r_valid_i = rv;
    data_r_ID_i    = rid;
    data_r_rdata_i = rd;
    data_r_opc_i   = op;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, 64'(data_r_valid_o), 64'(e_valid));
    for (int j = 0; j < NM; j++) check({tag, "_rdata"}, 64'(data_r_rdata_o[j]), 64'(m_rdata));
    check({tag, "_opc"},   64'(data_r_opc_o), 64'({NM{m_opc}}));
    check({tag, "_full"},  64'(outstanding_full_o), 64'(model_full()));
    check({tag, "_rerr"},  64'(resp_err_o),  64'(e_rerr));
    check({tag, "_ierr"},  64'(issue_err_o), 64'(e_ierr));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(data_r_valid_o), 64'd0);
    for (int j = 0; j < NM; j++) check({tag, "_rdata"}, 64'(data_r_rdata_o[j]), 64'd0);
    check({tag, "_opc"},  64'(data_r_opc_o), 64'd0);
    check({tag, "_full"}, 64'(outstanding_full_o), 64'd0);
    check({tag, "_rerr"}, 64'(resp_err_o), 64'd0);
    check({tag, "_ierr"}, 64'(issue_err_o), 64'd0);
  endtask

  typedef struct {
    logic          req, gnt;
    logic [NM-1:0] id;
    logic          rv;
    logic [NM-1:0] rid;
    logic [DW-1:0] rd;
    logic          op;
    logic [NM-1:0] ev;
    logic [DW-1:0] erd;
    logic          eop;
    logic [NM-1:0] efull;
    logic          erer, eier;
  } vec_t;

  function automatic vec_t mk(input logic req, input logic gnt, input logic [NM-1:0] id,
                              input logic rv, input logic [NM-1:0] rid,
                              input logic [DW-1:0] rd, input logic op,
                              input logic [NM-1:0] ev, input logic [DW-1:0] erd,
                              input logic eop, input logic [NM-1:0] efull,
                              input logic erer, input logic eier);
    vec_t v;
    v.req = req; v.gnt = gnt; v.id = id; v.rv = rv; v.rid = rid; v.rd = rd; v.op = op;
    v.ev = ev; v.erd = erd; v.eop = eop; v.efull = efull; v.erer = erer; v.eier = eier;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    //             req gnt id       rv rid      rdata         op  e_valid  e_rdata       eop efull    rerr ierr
    tbl[0]  = mk(1, 1, 4'b0100, 0, 4'b0000, 32'h0,        0,  4'b0000, 32'h0,        0, 4'b0000, 0, 0);
    tbl[1]  = mk(0, 0, 4'b0000, 0, 4'b0000, 32'h0,        0,  4'b0000, 32'h0,        0, 4'b0000, 0, 0);
    tbl[2]  = mk(0, 0, 4'b0000, 0, 4'b0000, 32'h0,        0,  4'b0000, 32'h0,        0, 4'b0000, 0, 0);
    tbl[3]  = mk(0, 0, 4'b0000, 1, 4'b0100, 32'hDEADBEEF, 0,  4'b0100, 32'hDEADBEEF, 0, 4'b0000, 0, 0);
    tbl[4]  = mk(1, 1, 4'b0010, 0, 4'b0000, 32'h0,        0,  4'b0000, 32'hDEADBEEF, 0, 4'b0000, 0, 0);
    tbl[5]  = mk(1, 1, 4'b0010, 0, 4'b0000, 32'h0,        0,  4'b0000, 32'hDEADBEEF, 0, 4'b0010, 0, 0);
    tbl[6]  = mk(1, 1, 4'b0010, 0, 4'b0000, 32'h0,        0,  4'b0000, 32'hDEADBEEF, 0, 4'b0010, 0, 1);
    tbl[7]  = mk(1, 1, 4'b0001, 0, 4'b0000, 32'h0,        0,  4'b0000, 32'hDEADBEEF, 0, 4'b0010, 0, 0);
    tbl[8]  = mk(1, 1, 4'b0001, 1, 4'b0001, 32'h12345678, 1,  4'b0001, 32'h12345678, 1, 4'b0010, 0, 0);
    tbl[9]  = mk(1, 1, 4'b0001, 0, 4'b0000, 32'h0,        0,  4'b0000, 32'h12345678, 1, 4'b0011, 0, 0);
    tbl[10] = mk(0, 0, 4'b0000, 1, 4'b0011, 32'hBAD0BAD0, 0,  4'b0000, 32'h12345678, 1, 4'b0011, 1, 0);
    tbl[11] = mk(1, 1, 4'b0100, 1, 4'b1000, 32'hBAD1BAD1, 0,  4'b0000, 32'h12345678, 1, 4'b0011, 1, 0);
    tbl[12] = mk(0, 0, 4'b0000, 1, 4'b0001, 32'h000000A1, 0,  4'b0001, 32'h000000A1, 0, 4'b0010, 0, 0);
    tbl[13] = mk(0, 0, 4'b0000, 1, 4'b0010, 32'h000000A2, 1,  4'b0010, 32'h000000A2, 1, 4'b0000, 0, 0);
    tbl[14] = mk(0, 0, 4'b0000, 1, 4'b0100, 32'h000000A3, 0,  4'b0100, 32'h000000A3, 0, 4'b0000, 0, 0);
    tbl[15] = mk(1, 1, 4'b0000, 0, 4'b0000, 32'h0,        0,  4'b0000, 32'h000000A3, 0, 4'b0000, 0, 1);
    tbl[16] = mk(1, 0, 4'b0101, 0, 4'b0000, 32'h0,        0,  4'b0000, 32'h000000A3, 0, 4'b0000, 0, 0);
    tbl[17] = mk(0, 1, 4'b0101, 0, 4'b0000, 32'h0,        0,  4'b0000, 32'h000000A3, 0, 4'b0000, 0, 0);

    rst_n          = 1'b0;
    data_req_i     = 1'b0;
    data_gnt_i     = 1'b0;
    data_ID_i      = '0;
    data_r_valid_i = 1'b0;
    data_r_ID_i    = '0;
    data_r_rdata_i = '0;
    data_r_opc_i   = 1'b0;
    model_reset();

    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 18; i++) begin
      string tag;
      tag = $sformatf("t%0d", i);
      drive(tbl[i].req, tbl[i].gnt, tbl[i].id, tbl[i].rv, tbl[i].rid, tbl[i].rd, tbl[i].op);
      check({tag, "_valid"}, 64'(data_r_valid_o), 64'(tbl[i].ev));
      for (int j = 0; j < NM; j++) check({tag, "_rdata"}, 64'(data_r_rdata_o[j]), 64'(tbl[i].erd));
      check({tag, "_opc"},  64'(data_r_opc_o), 64'({NM{tbl[i].eop}}));
      check({tag, "_full"}, 64'(outstanding_full_o), 64'(tbl[i].efull));
      check({tag, "_rerr"}, 64'(resp_err_o), 64'(tbl[i].erer));
      check({tag, "_ierr"}, 64'(issue_err_o), 64'(tbl[i].eier));
    end

    // Reset mid-operation: master 1 saturated and a response sitting in the register.
    drive(1, 1, 4'b0010, 1, 4'b0001, 32'h55AA55AA, 1);
    check_model("pre_rst");
    check("pre_rst_full1", 64'(outstanding_full_o[1]), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    model_reset();
    drive(0, 0, 4'b0000, 0, 4'b0000, 32'h0, 0);
    check_all_zero("in_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 4'b0000, 1, 4'b0010, 32'h11112222, 0);
    check("post_rst_rerr", 64'(resp_err_o), 64'd1);
    check("post_rst_valid", 64'(data_r_valid_o), 64'd0);
    check_model("post_rst");

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [NM-1:0] id, rid;
      int sel;
      sel = int'($urandom_range(0, 9));
      id  = (sel < 7) ? NM'(1 << $urandom_range(0, NM - 1)) : ((sel == 7) ? '0 : NM'($urandom));
      sel = int'($urandom_range(0, 9));
      rid = (sel < 8) ? NM'(1 << $urandom_range(0, NM - 1)) : ((sel == 8) ? '0 : NM'($urandom));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), id,
            1'($urandom_range(0, 4) < 3), rid, $urandom, 1'($urandom_range(0, 1)));
      check_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
